// File: rtl/imm_encoder_pkg.sv
// Shared processor definitions for immediate encoding: immediate classes,
// field widths and the loader FSM state type.
package imm_encoder_pkg;

   typedef enum logic [1:0] {
      IMM_DP  = 2'b00,
      IMM_MEM = 2'b01,
      IMM_BR  = 2'b10,
      IMM_BAD = 2'b11
   } imm_src_t;

   localparam int IMM_FIELD_W = 19;
   localparam int IMM_EXT_W   = 22;
   localparam int IMM_SHORT_W = 7;
   localparam int INSTR_W     = 32;
   localparam int HI_W        = INSTR_W - IMM_FIELD_W;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } enc_state_t;

endpackage

// File: rtl/imm_encoder_pack.sv
// imm_pack: combinational range check of an extended immediate against its
// class and packing of the 19-bit field under the pass-through upper bits.
module imm_pack
   import imm_encoder_pkg::*;
(
   input  logic [IMM_EXT_W-1:0] imm_i,
   input  imm_src_t             src_i,
   input  logic [HI_W-1:0]      hi_i,
   output logic [INSTR_W-1:0]   word_o,
   output logic                 legal_o
);

   logic [IMM_FIELD_W-1:0] field;

   always_comb begin
      legal_o = 1'b0;
      field   = '0;
      case (src_i)
         IMM_DP, IMM_MEM: begin
            // Short classes carry only 7 significant bits, zero-extended in the field.
            legal_o = (imm_i[IMM_EXT_W-1:IMM_SHORT_W] == '0);
            field   = {{(IMM_FIELD_W-IMM_SHORT_W){1'b0}}, imm_i[IMM_SHORT_W-1:0]};
         end
         IMM_BR: begin
            legal_o = (imm_i[IMM_EXT_W-1:IMM_FIELD_W] == '0);
            field   = imm_i[IMM_FIELD_W-1:0];
         end
         default: begin
            legal_o = 1'b0;
            field   = '0;
         end
      endcase
   end

   assign word_o = {hi_i, field};

endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: accepts immediates, packs them into instruction words and writes
// them to consecutive instruction-memory addresses. Optional IMM_ENCODER_ERRCNT_EN
// adds a saturating 8-bit count of rejected beats on err_cnt.
module imm_encoder
   import imm_encoder_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [IMM_EXT_W-1:0] in_imm,
   input  logic [1:0]           in_src,
   input  logic [HI_W-1:0]      in_hi,
   input  logic                 clear,
   output logic                 mem_we,
   output logic [AW-1:0]        mem_addr,
   output logic [INSTR_W-1:0]   mem_wdata,
   output logic                 full,
   output logic                 err,
   output logic                 err_sticky,
   output logic [AW:0]          count
`ifdef IMM_ENCODER_ERRCNT_EN
   ,
   output logic [7:0]           err_cnt
`endif
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   enc_state_t           state_q, state_d;
   logic [AW:0]          count_q, count_d;
   logic [AW-1:0]        addr_q, addr_d;
   logic [INSTR_W-1:0]   wdata_q, wdata_d;
   logic                 err_q, err_d;
   logic                 sticky_q, sticky_d;
   logic [INSTR_W-1:0]   pack_word;
   logic                 pack_legal;
   logic                 hs;

   imm_pack u_pack (
      .imm_i   (in_imm),
      .src_i   (imm_src_t'(in_src)),
      .hi_i    (in_hi),
      .word_o  (pack_word),
      .legal_o (pack_legal)
   );

   assign full     = (count_q == FULL_CNT);
   assign in_ready = (state_q == ST_IDLE) && !full;
   assign hs       = in_valid && in_ready;
   // A clear or reset arriving in the WRITE cycle suppresses the strobe.
   assign mem_we   = (state_q == ST_WRITE) && !clear && rst_n;

`ifdef IMM_ENCODER_ERRCNT_EN
   logic [7:0] errcnt_q, errcnt_d;
`endif

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      err_d    = 1'b0;
      sticky_d = sticky_q;
`ifdef IMM_ENCODER_ERRCNT_EN
      errcnt_d = errcnt_q;
`endif
      if (clear) begin
         state_d  = ST_IDLE;
         count_d  = '0;
         sticky_d = 1'b0;
`ifdef IMM_ENCODER_ERRCNT_EN
         errcnt_d = '0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (hs) begin
                  if (pack_legal) begin
                     addr_d  = count_q[AW-1:0];
                     wdata_d = pack_word;
                     state_d = ST_WRITE;
                  end else begin
                     err_d    = 1'b1;
                     sticky_d = 1'b1;
`ifdef IMM_ENCODER_ERRCNT_EN
                     if (errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
`endif
                  end
               end
            end
            ST_WRITE: begin
               count_d = count_q + (AW+1)'(1);
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         count_q  <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         err_q    <= 1'b0;
         sticky_q <= 1'b0;
`ifdef IMM_ENCODER_ERRCNT_EN
         errcnt_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         err_q    <= err_d;
         sticky_q <= sticky_d;
`ifdef IMM_ENCODER_ERRCNT_EN
         errcnt_q <= errcnt_d;
`endif
      end
   end

   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign err        = err_q;
   assign err_sticky = sticky_q;
   assign count      = count_q;
`ifdef IMM_ENCODER_ERRCNT_EN
   assign err_cnt    = errcnt_q;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder with a 4-word memory: packing, range check,
// error reporting, fill-to-full, clear and reset during a write.
module tb_imm_encoder;

   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [21:0]   in_imm;
   logic [1:0]    in_src;
   logic [12:0]   in_hi;
   logic          clear;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          full;
   logic          err;
   logic          err_sticky;
   logic [AW:0]   count;
`ifdef IMM_ENCODER_ERRCNT_EN
   logic [7:0]    err_cnt;
`endif

   int checks   = 0;
   int failures = 0;
   int nwr;

   imm_encoder #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_imm     (in_imm),
      .in_src     (in_src),
      .in_hi      (in_hi),
      .clear      (clear),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .full       (full),
      .err        (err),
      .err_sticky (err_sticky),
      .count      (count)
`ifdef IMM_ENCODER_ERRCNT_EN
      ,
      .err_cnt    (err_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_ready"},  32'(in_ready),   32'd1);
      check({tag, "_we"},     32'(mem_we),     32'd0);
      check({tag, "_addr"},   32'(mem_addr),   32'd0);
      check({tag, "_wdata"},  mem_wdata,       32'd0);
      check({tag, "_full"},   32'(full),       32'd0);
      check({tag, "_err"},    32'(err),        32'd0);
      check({tag, "_sticky"}, 32'(err_sticky), 32'd0);
      check({tag, "_count"},  32'(count),      32'd0);
   endtask

   task automatic beat(input logic [1:0] src, input logic [21:0] imm, input logic [12:0] hi);
      in_valid = 1'b1;
      in_src   = src;
      in_imm   = imm;
      in_hi    = hi;
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_imm   = '0;
      in_src   = 2'b00;
      in_hi    = '0;
      clear    = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      check_reset_state("reset");

      // Data-process immediate.
      beat(2'b00, 22'h00005A, 13'h1ABC);
      tick();
      in_valid = 1'b0;
      check("dp_we",    32'(mem_we),   32'd1);
      check("dp_addr",  32'(mem_addr), 32'd0);
      check("dp_wdata", mem_wdata,     {13'h1ABC, 19'h0005A});
      check("dp_ready_write", 32'(in_ready), 32'd0);
      tick();
      check("dp_we_off", 32'(mem_we), 32'd0);
      check("dp_count",  32'(count),  32'd1);

      // Largest legal branch offset, then one past it.
      beat(2'b10, 22'h07FFFF, 13'h0001);
      tick();
      in_valid = 1'b0;
      check("br_we",    32'(mem_we),   32'd1);
      check("br_addr",  32'(mem_addr), 32'd1);
      check("br_wdata", mem_wdata,     {13'h0001, 19'h7FFFF});
      tick();
      check("br_count", 32'(count), 32'd2);
      beat(2'b10, 22'h080000, 13'h0002);
      tick();
      in_valid = 1'b0;
      check("br_bad_err",    32'(err),        32'd1);
      check("br_bad_sticky", 32'(err_sticky), 32'd1);
      check("br_bad_we",     32'(mem_we),     32'd0);
      check("br_bad_hold",   mem_wdata,       {13'h0001, 19'h7FFFF});
      tick();
      check("br_bad_err_fall", 32'(err),   32'd0);
      check("br_bad_count",    32'(count), 32'd2);

      // Clear alone restarts count and sticky error.
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clr_count",  32'(count),      32'd0);
      check("clr_sticky", 32'(err_sticky), 32'd0);

      // Back-to-back rejects: short class overflow then illegal class.
      beat(2'b01, 22'h000080, 13'h0003);
      tick();
      check("mem_bad_err", 32'(err),    32'd1);
      check("mem_bad_we",  32'(mem_we), 32'd0);
      beat(2'b11, 22'h000001, 13'h0004);
      tick();
      in_valid = 1'b0;
      check("ill_err",    32'(err),        32'd1);
      check("ill_we",     32'(mem_we),     32'd0);
      check("ill_sticky", 32'(err_sticky), 32'd1);
      tick();
      check("ill_err_fall", 32'(err),   32'd0);
      check("ill_count",    32'(count), 32'd0);
`ifdef IMM_ENCODER_ERRCNT_EN
      check("errcnt", 32'(err_cnt), 32'd2);
`endif

      // Fill the memory with in_valid held.
      nwr = 0;
      beat(2'b00, 22'h00003C, 13'h0AAA);
      for (int i = 0; i < 14; i++) begin
         tick();
         if (mem_we) begin
            check("fill_addr",  32'(mem_addr), 32'(nwr));
            check("fill_wdata", mem_wdata,     {13'h0AAA, 19'h0003C});
            nwr++;
         end
      end
      check("fill_writes", 32'(nwr),      32'd4);
      check("fill_full",   32'(full),     32'd1);
      check("fill_ready",  32'(in_ready), 32'd0);
      check("fill_count",  32'(count),    32'd4);
      check("fill_hold",   32'(mem_addr), 32'd3);
      check("fill_we",     32'(mem_we),   32'd0);
      in_valid = 1'b0;

      // Clear with a simultaneous legal handshake drops the beat.
      clear = 1'b1;
      tick();
      beat(2'b01, 22'h000011, 13'h0005);
      tick();
      clear    = 1'b0;
      in_valid = 1'b0;
      check("clrhs_we",    32'(mem_we),   32'd0);
      check("clrhs_count", 32'(count),    32'd0);
      check("clrhs_ready", 32'(in_ready), 32'd1);
      check("clrhs_addr",  32'(mem_addr), 32'd3);
      tick();
      check("clrhs_we2", 32'(mem_we), 32'd0);

      // Clear during WRITE aborts the strobe.
      beat(2'b00, 22'h000001, 13'h0006);
      tick();
      in_valid = 1'b0;
      check("clrwr_pre_we", 32'(mem_we), 32'd1);
      clear = 1'b1;
      #1;
      check("clrwr_we", 32'(mem_we), 32'd0);
      tick();
      clear = 1'b0;
      check("clrwr_count", 32'(count),  32'd0);
      check("clrwr_we2",   32'(mem_we), 32'd0);

      // Reset during WRITE after a write and a reject.
      beat(2'b00, 22'h00007F, 13'h1FFF);
      tick();
      in_valid = 1'b0;
      tick();
      beat(2'b11, 22'h000000, 13'h0000);
      tick();
      check("pre_rst_sticky", 32'(err_sticky), 32'd1);
      beat(2'b10, 22'h012345, 13'h1234);
      tick();
      in_valid = 1'b0;
      check("pre_rst_we", 32'(mem_we), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_wr_we", 32'(mem_we), 32'd0);
      tick();
      rst_n = 1'b1;
      check_reset_state("rst_wr");
`ifdef IMM_ENCODER_ERRCNT_EN
      check("rst_errcnt", 32'(err_cnt), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
